// File: rtl/fir_decim_mac_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the decimating
// complex FIR MAC engine.
package fir_decim_mac_pkg;

  localparam int TAPS    = 256;
  localparam int DECIM   = 8;
  localparam int IN_W    = 24;
  localparam int PROD_W  = 2 * IN_W;
  localparam int ACC_W   = 56;
  localparam int BUF_AW  = 9;
  localparam int Q_SHIFT = 23;

  localparam int TAP_W   = $clog2(TAPS);
  localparam int DECIM_W = $clog2(DECIM);

  localparam logic [TAP_W-1:0]   TAP_LAST   = TAP_W'(TAPS - 1);
  localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM - 1);

  localparam logic [IN_W-1:0] SAT_MAX = 24'h7F_FFFF;
  localparam logic [IN_W-1:0] SAT_MIN = 24'h80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Q-format rescale then clamp: in range only when every bit above the
  // output sign bit matches it.
  function automatic logic [IN_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> Q_SHIFT;
    if ((&sh[ACC_W-1:IN_W-1]) || (~|sh[ACC_W-1:IN_W-1])) begin
      return sh[IN_W-1:0];
    end else if (sh[ACC_W-1]) begin
      return SAT_MIN;
    end else begin
      return SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port
// with single-cycle latency. Contents are never reset.
module fir_sample_ram #(
  parameter int AW = 9,
  parameter int DW = 48
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fir_decim_mac.sv
// Decimating complex FIR MAC: buffers I/Q samples and, every DECIM inputs,
// runs one TAPS-cycle pass aligned to the coefficient sequencer's stream.
//
// state | meaning
// IDLE  | waiting for a due pass; coeff_start fires on acceptance
// PRIME | two cycles covering sequencer and buffer read latency
// ACCUM | TAPS MAC cycles, newest sample paired with coeff[0]
// DONE  | y registers hold the new result, y_avail high, busy drops
module fir_decim_mac
  import fir_decim_mac_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            x_avail,
  input  logic [IN_W-1:0] x_real,
  input  logic [IN_W-1:0] x_imag,
  output logic            coeff_start,
  input  logic [IN_W-1:0] coeff,
  output logic            y_avail,
  output logic [IN_W-1:0] y_real,
  output logic [IN_W-1:0] y_imag,
  output logic            busy,
  output logic            overrun
);

  logic [BUF_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;
  logic               pass_due_q, pass_due_d;
  logic [BUF_AW-1:0]  base_q, base_d;
  logic [BUF_AW-1:0]  rd_ptr_q, rd_ptr_d;

  state_e             state_q, state_d;
  logic               prime_q, prime_d;
  logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic [IN_W-1:0]    y_real_q, y_real_d;
  logic [IN_W-1:0]    y_imag_q, y_imag_d;
  logic               y_avail_q, y_avail_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               coeff_start_c;

  logic [PROD_W-1:0]        rd_data;
  logic signed [IN_W-1:0]   rd_x_r, rd_x_i, coeff_s;
  logic signed [PROD_W-1:0] prod_r, prod_i;

  fir_sample_ram #(
    .AW (BUF_AW),
    .DW (PROD_W)
  ) u_ram (
    .clock (clock),
    .we    (x_avail),
    .waddr (wr_ptr_q),
    .wdata ({x_real, x_imag}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_x_r  = rd_data[PROD_W-1:IN_W];
  assign rd_x_i  = rd_data[IN_W-1:0];
  assign coeff_s = coeff;
  assign prod_r  = rd_x_r * coeff_s;
  assign prod_i  = rd_x_i * coeff_s;

  // Write side never stalls; base marks the newest sample of a due pass.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    decim_cnt_d = decim_cnt_q;
    pass_due_d  = 1'b0;
    base_d      = base_q;
    if (x_avail) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (decim_cnt_q == DECIM_LAST) begin
        decim_cnt_d = '0;
        pass_due_d  = 1'b1;
        base_d      = wr_ptr_q;
      end else begin
        decim_cnt_d = decim_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    prime_d       = prime_q;
    tap_cnt_d     = tap_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    acc_r_d       = acc_r_q;
    acc_i_d       = acc_i_q;
    y_real_d      = y_real_q;
    y_imag_d      = y_imag_q;
    y_avail_d     = 1'b0;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    coeff_start_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (pass_due_q) begin
          coeff_start_c = 1'b1;
          state_d       = PRIME;
          prime_d       = 1'b0;
          busy_d        = 1'b1;
          acc_r_d       = '0;
          acc_i_d       = '0;
          rd_ptr_d      = base_q;
        end
      end
      PRIME: begin
        // rd_ptr holds base for both cycles so the newest sample lands with coeff[0]
        if (!prime_q) begin
          prime_d = 1'b1;
        end else begin
          state_d   = ACCUM;
          tap_cnt_d = TAP_LAST;
          rd_ptr_d  = rd_ptr_q - 1'b1;
        end
      end
      ACCUM: begin
        rd_ptr_d = rd_ptr_q - 1'b1;
        acc_r_d  = acc_r_q + sext_prod(prod_r);
        acc_i_d  = acc_i_q + sext_prod(prod_i);
        if (tap_cnt_q == '0) begin
          state_d   = DONE;
          y_real_d  = sat_out(acc_r_d);
          y_imag_d  = sat_out(acc_i_d);
          y_avail_d = 1'b1;
        end else begin
          tap_cnt_d = tap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (pass_due_q && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      decim_cnt_q <= '0;
      pass_due_q  <= 1'b0;
      base_q      <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      prime_q     <= 1'b0;
      tap_cnt_q   <= '0;
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      y_real_q    <= '0;
      y_imag_q    <= '0;
      y_avail_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      decim_cnt_q <= decim_cnt_d;
      pass_due_q  <= pass_due_d;
      base_q      <= base_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      prime_q     <= prime_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      y_real_q    <= y_real_d;
      y_imag_q    <= y_imag_d;
      y_avail_q   <= y_avail_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign coeff_start = coeff_start_c & ~reset;
  assign y_avail     = y_avail_q;
  assign y_real      = y_real_q;
  assign y_imag      = y_imag_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fir_decim_mac.sv
// Directed bench for fir_decim_mac with a behavioural coefficient sequencer
// and a buffer-mirroring scoreboard.
module tb_fir_decim_mac;
  import fir_decim_mac_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        x_avail;
  logic [23:0] x_real, x_imag, coeff;
  logic        coeff_start, y_avail, busy, overrun;
  logic [23:0] y_real, y_imag;

  fir_decim_mac dut (
    .clock       (clock),
    .reset       (reset),
    .x_avail     (x_avail),
    .x_real      (x_real),
    .x_imag      (x_imag),
    .coeff_start (coeff_start),
    .coeff       (coeff),
    .y_avail     (y_avail),
    .y_real      (y_real),
    .y_imag      (y_imag),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] r;
    logic [23:0] i;
  } exp_t;

  exp_t        q[$];
  logic [47:0] mdl_mem [512];
  int          mdl_wr, mdl_cnt, mdl_free, mdl_accepts;
  logic        mdl_ovr;
  int          coeff_mode;
  int          cyc;
  int          n_checks, n_err;
  int          start_cyc, n_starts, n_y;
  logic        prev_cs;
  logic        check_en;
  logic [23:0] last_y_r, last_y_i;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] coef_of(input int k);
    case (coeff_mode)
      0:       return 24'h000100;
      1:       return 24'(k * 256);
      default: return 24'h7FFFFF;
    endcase
  endfunction

  function automatic exp_t predict(input int base);
    longint ar, ai, cv;
    logic [47:0] s;
    exp_t e;
    ar = 0;
    ai = 0;
    for (int k = 0; k < TAPS; k++) begin
      s  = mdl_mem[(base - k) & 511];
      cv = longint'($signed(coef_of(k)));
      ar += longint'($signed(s[47:24])) * cv;
      ai += longint'($signed(s[23:0])) * cv;
    end
    ar = ar >>> 23;
    ai = ai >>> 23;
    if (ar > 64'sd8388607) e.r = 24'h7FFFFF;
    else if (ar < -64'sd8388608) e.r = 24'h800000;
    else e.r = ar[23:0];
    if (ai > 64'sd8388607) e.i = 24'h7FFFFF;
    else if (ai < -64'sd8388608) e.i = 24'h800000;
    else e.i = ai[23:0];
    return e;
  endfunction

  // Sequencer model: coeff[k] is presented for the whole of cycle start+3+k.
  initial begin
    int   ctr;
    logic cs;
    ctr   = 0;
    coeff = '0;
    forever begin
      @(negedge clock);
      cs = coeff_start;
      @(posedge clock);
      #1;
      if (cs === 1'b1) ctr = 1;
      else if (ctr > 0 && ctr < 300) ctr++;
      coeff = (ctr >= 3 && ctr - 3 < TAPS) ? coef_of(ctr - 3) : 24'h0;
    end
  end

  initial begin
    prev_cs = 1'b0;
    forever begin
      @(negedge clock);
      if (coeff_start === 1'b1) begin
        chk("coeff_start_width", 64'(prev_cs), 64'd0);
        chk("coeff_start_while_busy", 64'(busy), 64'd0);
        start_cyc = cyc;
        n_starts++;
      end
      prev_cs = coeff_start;
      if (y_avail === 1'b1 && check_en) begin
        exp_t e;
        n_y++;
        last_y_r = y_real;
        last_y_i = y_imag;
        if (q.size() == 0) begin
          chk("unexpected_y_avail", 64'(y_avail), 64'd0);
        end else begin
          e = q.pop_front();
          chk("y_real", 64'(y_real), 64'(e.r));
          chk("y_imag", 64'(y_imag), 64'(e.i));
          chk("latency", 64'(cyc - start_cyc), 64'd259);
        end
      end
    end
  end

  // Caller is #1 after a posedge; one strobe, then idle until gap cycles elapse.
  task automatic strobe(input logic [23:0] r, input logic [23:0] i, input int gap);
    int base, s;
    x_avail = 1'b1;
    x_real  = r;
    x_imag  = i;
    mdl_mem[mdl_wr] = {r, i};
    base   = mdl_wr;
    mdl_wr = (mdl_wr + 1) % 512;
    if (mdl_cnt == DECIM - 1) begin
      mdl_cnt = 0;
      s = cyc + 1;
      if (s >= mdl_free) begin
        mdl_free = s + 260;
        q.push_back(predict(base));
        mdl_accepts++;
      end else begin
        mdl_ovr = 1'b1;
      end
    end else begin
      mdl_cnt++;
    end
    @(posedge clock);
    #1;
    x_avail = 1'b0;
    repeat (gap - 1) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    x_avail = 1'b0;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    mdl_wr   = 0;
    mdl_cnt  = 0;
    mdl_free = 0;
    mdl_ovr  = 1'b0;
    q.delete();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #900000;
    n_err++;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    int s0, a0, y0;
    n_checks = 0; n_err = 0; n_starts = 0; n_y = 0; start_cyc = 0;
    mdl_accepts = 0; coeff_mode = 0; check_en = 1'b0;
    reset = 1'b1; x_avail = 1'b0; x_real = '0; x_imag = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill the whole buffer with zeros so the model matches from the first pass.
    for (int n = 0; n < 512; n++) begin
      x_avail = 1'b1;
      @(posedge clock);
      #1;
    end
    x_avail = 1'b0;
    for (int n = 0; n < 512; n++) mdl_mem[n] = '0;
    repeat (3) @(posedge clock);
    #1;
    pulse_reset();
    check_en = 1'b1;

    chk("rst_coeff_start", 64'(coeff_start), 64'd0);
    chk("rst_y_avail", 64'(y_avail), 64'd0);
    chk("rst_y_real", 64'(y_real), 64'd0);
    chk("rst_y_imag", 64'(y_imag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_wr_ptr", 64'(dut.wr_ptr_q), 64'd0);
    chk("rst_decim_cnt", 64'(dut.decim_cnt_q), 64'd0);

    // Impulse: newest-first ordering against coeff[k] = k*0x100.
    coeff_mode = 1;
    strobe(24'h400000, 24'h0, 33);
    for (int n = 0; n < 7; n++) strobe(24'h0, 24'h0, 33);
    drain();
    chk("impulse_first_real", 64'(last_y_r), 64'd896);
    chk("impulse_first_imag", 64'(last_y_i), 64'd0);
    for (int n = 0; n < 256; n++) strobe(24'h0, 24'h0, 33);
    drain();

    // DC gain, then an 80-strobe window for the decimation count.
    coeff_mode = 0;
    for (int n = 0; n < 264; n++) strobe(24'h100000, 24'h100000, 33);
    drain();
    y0 = n_y;
    for (int n = 0; n < 80; n++) strobe(24'h100000, 24'h100000, 40);
    drain();
    chk("decim_outputs", 64'(n_y - y0), 64'd10);
    chk("dc_real", 64'(last_y_r), 64'h2000);
    chk("dc_imag", 64'(last_y_i), 64'h2000);

    // Saturation at both rails.
    coeff_mode = 2;
    for (int n = 0; n < 264; n++) strobe(24'h7FFFFF, 24'h7FFFFF, 33);
    drain();
    chk("sat_pos_real", 64'(last_y_r), 64'h7FFFFF);
    chk("sat_pos_imag", 64'(last_y_i), 64'h7FFFFF);
    for (int n = 0; n < 264; n++) strobe(24'h800000, 24'h800000, 33);
    drain();
    chk("sat_neg_real", 64'(last_y_r), 64'h800000);
    chk("sat_neg_imag", 64'(last_y_i), 64'h800000);
    chk("no_overrun_at_rate", 64'(overrun), 64'(mdl_ovr));

    // Overrun: a pass every 80 cycles cannot keep up.
    pulse_reset();
    coeff_mode = 0;
    s0 = n_starts;
    a0 = mdl_accepts;
    for (int n = 0; n < 24; n++) strobe(24'h012345, 24'hFEDCBA, 10);
    chk("overrun_set", 64'(overrun), 64'(mdl_ovr));
    chk("starts_while_overrun", 64'(n_starts - s0), 64'(mdl_accepts - a0));
    drain();
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of ACCUM aborts the pass.
    pulse_reset();
    s0 = n_starts;
    for (int n = 0; n < 8; n++) strobe(24'h020000, 24'h030000, 40);
    chk("mid_pass_started", 64'(n_starts - s0), 64'd1);
    for (int w = 0; w < 400; w++) begin
      if (cyc == start_cyc + 100) break;
      @(posedge clock);
      #1;
    end
    chk("mid_pass_reached", 64'(cyc - start_cyc), 64'd100);
    pulse_reset();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_decim_cnt", 64'(dut.decim_cnt_q), 64'd0);
    chk("abort_y_avail", 64'(y_avail), 64'd0);
    y0 = n_y;
    repeat (300) @(posedge clock);
    #1;
    chk("abort_no_output", 64'(n_y - y0), 64'd0);
    for (int n = 0; n < 8; n++) strobe(24'h020000, 24'h030000, 40);
    drain();
    chk("fresh_pass_output", 64'(n_y - y0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
